// File: rtl/mips_prog_loader_pkg.sv
// mips_loader_pkg: shared state encoding and constants for the MIPS32 program loader.
package mips_loader_pkg;
   typedef enum logic [2:0] {IDLE, RECV, WRITE, RELEASE, DONE, ERROR} state_t;
   localparam logic [31:0] HLT_WORD_DEF = 32'hfc000000;
   localparam int BCNT_W = 2;
endpackage

// File: rtl/mips_prog_loader_if.sv
// mips_prog_loader_if: upstream byte stream plus instruction-memory write port.
interface mips_prog_loader_if #(parameter int ADDR_W = 10);
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   modport master (input s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (output s_valid, s_data, input s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: assembles big-endian words from a byte stream, writes them from address 0
// and releases the core with a start pulse once the HLT word has been stored.
module mips_prog_loader
   import mips_loader_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] HLT_WORD  = HLT_WORD_DEF
) (
   input  logic                 clk1,
   input  logic                 rst_n,
   input  logic                 start,
   mips_prog_loader_if.master   bus,
   output logic                 cpu_hold,
   output logic                 cpu_start,
   output logic                 busy,
   output logic                 done,
   output logic                 err_overflow,
   output logic [ADDR_W:0]      word_count
);
   state_t              state, nxt;
   logic [BCNT_W-1:0]   byte_cnt;
   logic [31:0]         shreg;
   logic [ADDR_W-1:0]   word_ptr;
   logic                xfer, last, idle_like;
   assign bus.s_ready = state == RECV;
   assign xfer        = bus.s_valid && bus.s_ready;
   assign last        = word_ptr == ADDR_W'(MEM_DEPTH - 1);
   assign idle_like   = state inside {IDLE, DONE, ERROR};
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE, ERROR: nxt = start ? RECV : state;
         RECV:              nxt = xfer && &byte_cnt ? WRITE : RECV;
         WRITE:             nxt = shreg == HLT_WORD ? RELEASE : last ? ERROR : RECV;
         RELEASE:           nxt = DONE;
         default:           nxt = IDLE;
      endcase
   end
   // status outputs are registered copies of the upcoming state so they line up with it
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         shreg         <= '0;
         word_ptr      <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         cpu_hold      <= 1'b1;
         cpu_start     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_overflow  <= 1'b0;
         word_count    <= '0;
      end else begin
         state        <= nxt;
         bus.mem_we   <= nxt == WRITE;
         cpu_start    <= nxt == RELEASE;
         cpu_hold     <= !(nxt inside {RELEASE, DONE});
         busy         <= nxt inside {RECV, WRITE};
         done         <= nxt == DONE;
         err_overflow <= nxt == ERROR;
         if (xfer) begin
            shreg    <= {shreg[23:0], bus.s_data};
            byte_cnt <= byte_cnt + 1'b1;
         end
         if (xfer && &byte_cnt) begin
            bus.mem_addr  <= word_ptr;
            bus.mem_wdata <= {shreg[23:0], bus.s_data};
         end
         if (state == WRITE) begin
            word_count <= word_count + 1'b1;
            if (nxt == RECV) word_ptr <= word_ptr + 1'b1;
         end
         if (start && idle_like) begin
            word_ptr   <= '0;
            byte_cnt   <= '0;
            word_count <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed checks of the loader at full depth and at a 4-word depth.
module tb_mips_prog_loader;
   import mips_loader_pkg::*;

   typedef struct {logic [31:0] w; logic [9:0] addr;} vec_t;
   typedef struct packed {logic [9:0] addr; logic [31:0] data;} wr_t;
   typedef struct packed {
      logic rdy, we; logic [9:0] addr; logic [31:0] wd;
      logic hold, st, busy, done, err; logic [10:0] wc;
   } obs_t;

   logic clk1 = 0, rst_n = 0, start0 = 0, start1 = 0, sv = 0, tgt = 0;
   logic [7:0] sd = 0;
   logic h0, cs0, bz0, d0, e0, h1, cs1, bz1, d1, e1;
   logic [10:0] wc0, wc1;
   obs_t o;
   wr_t log0[$], log1[$];
   int sc0 = 0, sc1 = 0, checks = 0, failures = 0;
   vec_t prog[9];

   always #5 clk1 = ~clk1;

   mips_prog_loader_if #(.ADDR_W(10)) b0 (), b1 ();
   assign b0.s_valid = sv && !tgt;
   assign b1.s_valid = sv && tgt;
   assign b0.s_data  = sd;
   assign b1.s_data  = sd;

   mips_prog_loader #(.ADDR_W(10), .MEM_DEPTH(1024)) u0 (
      .clk1(clk1), .rst_n(rst_n), .start(start0), .bus(b0.master),
      .cpu_hold(h0), .cpu_start(cs0), .busy(bz0), .done(d0), .err_overflow(e0), .word_count(wc0));
   mips_prog_loader #(.ADDR_W(10), .MEM_DEPTH(4)) u1 (
      .clk1(clk1), .rst_n(rst_n), .start(start1), .bus(b1.master),
      .cpu_hold(h1), .cpu_start(cs1), .busy(bz1), .done(d1), .err_overflow(e1), .word_count(wc1));

   always_comb
      o = tgt ? {b1.s_ready, b1.mem_we, b1.mem_addr, b1.mem_wdata, h1, cs1, bz1, d1, e1, wc1}
              : {b0.s_ready, b0.mem_we, b0.mem_addr, b0.mem_wdata, h0, cs0, bz0, d0, e0, wc0};

   always @(negedge clk1) begin
      if (b0.mem_we) log0.push_back({b0.mem_addr, b0.mem_wdata});
      if (b1.mem_we) log1.push_back({b1.mem_addr, b1.mem_wdata});
      sc0 += int'(cs0);
      sc1 += int'(cs1);
   end

   function automatic int logn();
      return tgt ? log1.size() : log0.size();
   endfunction
   function automatic wr_t logq(input int i);
      return tgt ? log1[i] : log0[i];
   endfunction
   function automatic int scn();
      return tgt ? sc1 : sc0;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      repeat (gap) @(negedge clk1);
      sd = b;
      sv = 1;
      while (!o.rdy && n < 64) begin
         @(negedge clk1);
         n++;
      end
      if (!o.rdy) begin
         checks++;
         failures++;
         $display("FAIL byte_accept: s_ready stayed low for %0d cycles, byte %h", n, b);
      end else @(negedge clk1);
      sv = 0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap, input logic [9:0] a);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8], int'($urandom_range(maxgap)));
         if (i != 0) chk("no_early_we", o.we, 0);
      end
      chk("we_after_4th", o.we, 1);
      chk("wr_addr", o.addr, a);
      chk("wr_data", o.wd, w);
   endtask

   task automatic pulse();
      @(negedge clk1);
      if (tgt) start1 = 1; else start0 = 1;
      @(negedge clk1);
      start0 = 0;
      start1 = 0;
   endtask

   task automatic clr();
      log0.delete();
      log1.delete();
      sc0 = 0;
      sc1 = 0;
   endtask

   task automatic load_prog(input int maxgap, input bit ign);
      for (int i = 0; i < 9; i++) begin
         send_word(prog[i].w, maxgap, prog[i].addr);
         if (ign && i == 3) begin
            pulse();
            chk("ign_start_busy", o.busy, 1);
            chk("ign_start_rdy", o.rdy, 1);
            chk("ign_start_wc", o.wc, 4);
         end
      end
   endtask

   task automatic check_prog();
      wr_t r;
      chk("n_writes", logn(), 9);
      for (int i = 0; i < 9 && i < logn(); i++) begin
         r = logq(i);
         chk("log_addr", r.addr, prog[i].addr);
         chk("log_data", r.data, prog[i].w);
      end
   endtask

   task automatic finish_release(input int expwc);
      @(negedge clk1);
      chk("rel_start", o.st, 1);
      chk("rel_hold", o.hold, 0);
      chk("rel_we", o.we, 0);
      @(negedge clk1);
      chk("done_start", o.st, 0);
      chk("done_flag", o.done, 1);
      chk("done_err", o.err, 0);
      chk("done_hold", o.hold, 0);
      chk("done_busy", o.busy, 0);
      chk("done_rdy", o.rdy, 0);
      chk("done_wc", o.wc, 32'(expwc));
      chk("start_pulses", scn(), 1);
   endtask

   task automatic chk_reset();
      chk("rst_rdy", o.rdy, 0);
      chk("rst_we", o.we, 0);
      chk("rst_addr", o.addr, 0);
      chk("rst_wdata", o.wd, 0);
      chk("rst_hold", o.hold, 1);
      chk("rst_start", o.st, 0);
      chk("rst_busy", o.busy, 0);
      chk("rst_done", o.done, 0);
      chk("rst_err", o.err, 0);
      chk("rst_wc", o.wc, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      prog[0] = '{32'h2801000a, 10'd0};
      prog[1] = '{32'h28020014, 10'd1};
      prog[2] = '{32'h28030019, 10'd2};
      prog[3] = '{32'h0ce77800, 10'd3};
      prog[4] = '{32'h0ce77800, 10'd4};
      prog[5] = '{32'h00222000, 10'd5};
      prog[6] = '{32'h0ce77800, 10'd6};
      prog[7] = '{32'h00832800, 10'd7};
      prog[8] = '{32'hfc000000, 10'd8};

      #12;
      chk_reset();
      tgt = 1;
      #1 chk_reset();
      tgt = 0;
      @(negedge clk1) rst_n = 1;
      repeat (2) @(negedge clk1);
      chk("idle_hold", o.hold, 1);
      chk("idle_rdy", o.rdy, 0);

      pulse();
      chk("recv_hold", o.hold, 1);
      chk("recv_busy", o.busy, 1);
      chk("recv_rdy", o.rdy, 1);
      clr();
      load_prog(0, 0);
      finish_release(9);
      check_prog();

      pulse();
      chk("restart_hold", o.hold, 1);
      chk("restart_wc", o.wc, 0);
      chk("restart_done", o.done, 0);
      chk("restart_busy", o.busy, 1);
      clr();
      load_prog(3, 1);
      finish_release(9);
      check_prog();

      tgt = 1;
      pulse();
      clr();
      for (int i = 0; i < 4; i++) send_word(32'h11110000 + i, 0, 10'(i));
      @(negedge clk1);
      chk("ovf_err", o.err, 1);
      chk("ovf_hold", o.hold, 1);
      chk("ovf_rdy", o.rdy, 0);
      chk("ovf_busy", o.busy, 0);
      chk("ovf_done", o.done, 0);
      chk("ovf_wc", o.wc, 4);
      sd = 8'haa;
      sv = 1;
      repeat (6) @(negedge clk1);
      sv = 0;
      chk("ovf_nwrites", logn(), 4);
      chk("ovf_still_rdy", o.rdy, 0);
      chk("ovf_still_err", o.err, 1);
      chk("ovf_no_start", scn(), 0);
      for (int i = 0; i < 4 && i < logn(); i++) chk("ovf_log_addr", logq(i).addr, 32'(i));

      pulse();
      chk("last_err_clr", o.err, 0);
      chk("last_wc_clr", o.wc, 0);
      clr();
      for (int i = 0; i < 3; i++) send_word(32'h22220000 + i, 0, 10'(i));
      send_word(32'hfc000000, 0, 10'd3);
      finish_release(4);
      chk("last_nwrites", logn(), 4);
      if (logn() == 4) chk("last_hlt_data", logq(3).data, 32'hfc000000);

      tgt = 0;
      pulse();
      clr();
      send_word(prog[0].w, 0, 10'd0);
      send_byte(prog[1].w[31:24], 0);
      send_byte(prog[1].w[23:16], 0);
      rst_n = 0;
      #1 chk_reset();
      @(negedge clk1) rst_n = 1;
      @(negedge clk1);
      chk("post_rst_idle_rdy", o.rdy, 0);
      pulse();
      clr();
      load_prog(1, 0);
      finish_release(9);
      check_prog();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Boot-time program loader that sits directly upstream of the pipelined MIPS32 core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into the core's instruction/data memory from address 0. It holds the core halted throughout the load, and after the HLT word (0xfc000000) has been written it releases the core with a one-cycle start pulse.

## Interface
- ADDR_W, 10, word-address width of the memory write port
- MEM_DEPTH, 1024, number of writable words (must be ≤ 2**ADDR_W)
- HLT_WORD, 32'hfc000000, word that terminates a load session
- clk1  in  1  single clock (core's phase-1 clock domain)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; opens a load session
- s_valid  in  1  upstream byte valid
- s_data  in  8  upstream byte, most-significant byte of each word first
- s_ready  out  1  loader can accept a byte
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  high keeps the core halted (drives HALTED, PC held at 0)
- cpu_start  out  1  one-cycle pulse; core clears TAKEN_BRANCH and begins at PC=0
- busy  out  1  session in progress (RECV or WRITE)
- done  out  1  sticky; last session ended on HLT_WORD
- err_overflow  out  1  sticky; MEM_DEPTH words written without HLT_WORD
- word_count  out  ADDR_W+1  words written in the current/last session

## Operation
- States: IDLE, RECV, WRITE, RELEASE, DONE, ERROR.
- IDLE: s_ready=0, cpu_hold=1. start → RECV. word_ptr=0, byte_cnt=0, word_count=0, done=0, err_overflow=0.
- RECV: s_ready=1. A byte transfers on a clock edge where s_valid&&s_ready. Each byte shifts in as shreg={shreg[23:0],s_data}, and byte_cnt increments. On the 4th byte → WRITE.
- WRITE: s_ready=0, mem_we=1, mem_addr=word_ptr, mem_wdata=shreg. At the edge, word_count increments. Exits:
  - word==HLT_WORD → RELEASE.
  - else word_ptr==MEM_DEPTH-1 → ERROR.
  - else word_ptr increments, byte_cnt=0 → RECV.
- RELEASE: cpu_start=1 and cpu_hold=0 for exactly one cycle → DONE.
- DONE: done=1, cpu_hold=0. start → new session as from IDLE; cpu_hold returns to 1 the following cycle.
- ERROR: err_overflow=1, cpu_hold stays 1. start → new session as from IDLE.
- start is ignored in RECV, WRITE and RELEASE.
- s_valid with s_ready=0 is not a transfer. Upstream holds s_data until the transfer completes; the loader never drops or duplicates a byte.
- mem_addr and mem_wdata are don't-care when mem_we=0. The implementation holds them at their last value.

## Timing
- All outputs are registered except s_ready, which is decoded from the state register.
- Reset values:
  - IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, cpu_start=0, busy=0, done=0, err_overflow=0, word_count=0.
- Latency: when the 4th byte transfers at edge N, mem_we is high for the cycle after edge N and the write commits at edge N+1.
- Throughput: at most one word per 5 cycles (4 byte cycles plus 1 WRITE cycle).
- HLT write: cpu_start is high in the cycle after the HLT write edge, and cpu_hold falls in that same cycle.
- Reset asserted mid-session: abort immediately, return to reset values, and discard the partial word. Words already written are not rolled back.
- Overflow boundary: a HLT_WORD written at address MEM_DEPTH-1 is a success (DONE), not an error.

## Structure
- Package mips_loader_pkg holds:
  - state enum: IDLE, RECV, WRITE, RELEASE, DONE, ERROR
  - HLT_WORD default constant
  - byte-count width constant (2)
- Single flat module; no sub-module is needed. The byte-assembly shift register stays inline.

## Test plan
- Basic load: stream the 9-word program 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 with s_valid held high → writes to addr 0..8 with exact words, one cpu_start pulse, done=1, word_count=9.
- Handshake gaps: same stream with s_valid randomly deasserted 0-3 cycles between bytes → identical writes; no write while byte_cnt<4.
- Overflow: MEM_DEPTH=4, stream five non-HLT words → writes at addr 0..3 only, err_overflow=1, cpu_hold stays 1, no cpu_start, s_ready=0.
- HLT at last slot: MEM_DEPTH=4, three words then fc000000 → done=1, err_overflow=0, cpu_start pulses.
- Reset mid-word: assert rst_n low after 2 bytes of word 1 → all outputs at reset values. A new start plus a fresh stream writes correctly from addr 0.
- Restart and ignored start: pulse start during RECV → no effect. Pulse start in DONE → cpu_hold=1, word_count=0, done=0, and a second program loads from addr 0.
